// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_unit                                                    |
// | Purpose  : Instruction fetch stage. Issues one instruction-memory         |
// |            request at a time, tracks the PC, and feeds the IF/ID         |
// |            pipeline register with stall, flush and redirect handling.    |
// | Options  : FETCH_SKID_EN - one-entry skid buffer that parks a response    |
// |            arriving during a decode stall. Without it, that word is      |
// |            discarded and fetched again.                                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallf,
    input  logic        stalld,
    input  logic        flushd,
    input  logic        pcsrce,
    input  logic [31:0] pctargete,
    output logic        imemreq,
    output logic [31:0] imemaddr,
    input  logic        imemgnt,
    input  logic        imemrvalid,
    input  logic [31:0] imemrdata,
    output logic [31:0] instrd,
    output logic [31:0] pcd,
    output logic [31:0] pcplus4d,
    output logic        validd
);

    localparam logic [0:0] c_REQ  = 1'b0;
    localparam logic [0:0] c_WAIT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] reqpc_q, reqpc_d;
    logic        drop_q, drop_d;
    logic [31:0] instrd_q, instrd_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcplus4d_q, pcplus4d_d;
    logic        validd_q, validd_d;

    logic        w_grant;
    logic        w_resp;
    logic        w_accept;
    logic        w_park;
    logic        w_refetch;
    logic        w_buf_valid;
    logic [31:0] w_buf_instr;
    logic [31:0] w_buf_pc;

    // A response that coincides with a redirect belongs to the old path, so
    // it is discarded outright rather than arming the drop flag.
    assign w_grant  = imemreq && imemgnt;
    assign w_resp   = (state_q == c_WAIT) && imemrvalid;
    assign w_accept = w_resp && !drop_q && !pcsrce;
    assign w_park   = w_accept && stalld && !flushd;

`ifdef FETCH_SKID_EN
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;

    // Skid buffer: park a response blocked by a decode stall; drain on release.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        if (flushd || pcsrce) begin
            buf_valid_d = 1'b0;
        end else if (w_park) begin
            buf_valid_d = 1'b1;
            buf_instr_d = imemrdata;
            buf_pc_d    = reqpc_q;
        end else if (buf_valid_q && !stalld) begin
            buf_valid_d = 1'b0;
        end
    end

    // Skid buffer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            buf_instr_q <= NOP_INSTR;
            buf_pc_q    <= 32'h0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    assign w_buf_valid = buf_valid_q;
    assign w_buf_instr = buf_instr_q;
    assign w_buf_pc    = buf_pc_q;
    assign w_refetch   = 1'b0;
`else
    assign w_buf_valid = 1'b0;
    assign w_buf_instr = NOP_INSTR;
    assign w_buf_pc    = 32'h0;
    assign w_refetch   = w_park;
`endif

    // FSM state register plus all fetch-side and IF/ID flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= c_REQ;
            pcf_q      <= RESET_PC;
            reqpc_q    <= RESET_PC;
            drop_q     <= 1'b0;
            instrd_q   <= NOP_INSTR;
            pcd_q      <= 32'h0;
            pcplus4d_q <= 32'h0;
            validd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcf_q      <= pcf_d;
            reqpc_q    <= reqpc_d;
            drop_q     <= drop_d;
            instrd_q   <= instrd_d;
            pcd_q      <= pcd_d;
            pcplus4d_q <= pcplus4d_d;
            validd_q   <= validd_d;
        end
    end

    // FSM next state: one request in flight, wait for its response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_REQ:   if (w_grant)    state_d = c_WAIT;
            c_WAIT:  if (imemrvalid) state_d = c_REQ;
            default: state_d = c_REQ;
        endcase
    end

    // FSM outputs: request only when fetch is free and nothing is parked.
    always_comb begin
        imemreq  = !reset && (state_q == c_REQ) && !stallf && !w_buf_valid;
        imemaddr = pcf_q;
    end

    // PC, request PC and drop flag; a redirect overrides every other PC update.
    always_comb begin
        pcf_d   = pcf_q;
        reqpc_d = reqpc_q;
        drop_d  = drop_q;
        if (w_grant) begin
            pcf_d   = pcf_q + 32'd4;
            reqpc_d = pcf_q;
        end
        if (w_refetch) begin
            pcf_d = reqpc_q;
        end
        if (w_resp) begin
            drop_d = 1'b0;
        end
        if (pcsrce) begin
            pcf_d = pctargete;
            if (((state_q == c_WAIT) && !imemrvalid) || w_grant) begin
                drop_d = 1'b1;
            end
        end
    end

    // IF/ID load: flush > stall > parked entry > new response > bubble.
    always_comb begin
        instrd_d   = instrd_q;
        pcd_d      = pcd_q;
        pcplus4d_d = pcplus4d_q;
        validd_d   = validd_q;
        if (flushd || (!stalld && !w_buf_valid && !w_accept)) begin
            instrd_d   = NOP_INSTR;
            pcd_d      = 32'h0;
            pcplus4d_d = 32'h0;
            validd_d   = 1'b0;
        end else if (!stalld && w_buf_valid) begin
            instrd_d   = w_buf_instr;
            pcd_d      = w_buf_pc;
            pcplus4d_d = w_buf_pc + 32'd4;
            validd_d   = 1'b1;
        end else if (!stalld) begin
            instrd_d   = imemrdata;
            pcd_d      = reqpc_q;
            pcplus4d_d = reqpc_q + 32'd4;
            validd_d   = 1'b1;
        end
    end

    assign instrd   = instrd_q;
    assign pcd      = pcd_q;
    assign pcplus4d = pcplus4d_q;
    assign validd   = validd_q;

endmodule
`default_nettype wire
